// File: rtl/wb_sdram_traffic_gen.sv
// wb_sdram_traffic_gen: self-checking Wishbone traffic generator for the SDRAM controller.
// A run writes cfg_num_bursts incrementing bursts from cfg_base_addr, then reads them back
// and compares each beat against the regenerated pattern under the cfg_sel byte mask.
//
// Ports:
//   sys_clk, sys_resetn       clock, synchronous active-low reset
//   start                     one-cycle launch pulse (ignored while busy)
//   cfg_base_addr/num_bursts/burst_len/sel   run configuration, latched on start
//   sdr_init_done             controller ready; first burst waits for it
//   wb_*                      Wishbone master port (cyc/stb/we/addr/dat/sel/cti out, ack/dat in)
//   busy, done, pass, timeout run status
//   err_count, first_err_addr mismatch statistics
//
// Optional build macro WB_TGEN_LFSR_EN: pattern is a Galois LFSR instead of a counter.
module wb_sdram_traffic_gen #(
    parameter int unsigned dw        = 32,
    parameter int unsigned APP_AW    = 26,
    parameter int unsigned BURST_MAX = 8,
    parameter logic [31:0] PAT_SEED  = 32'h1,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic              sys_clk,
    input  logic              sys_resetn,
    input  logic              start,
    input  logic [APP_AW-1:0] cfg_base_addr,
    input  logic [15:0]       cfg_num_bursts,
    input  logic [4:0]        cfg_burst_len,
    input  logic [dw/8-1:0]   cfg_sel,
    input  logic              sdr_init_done,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [APP_AW-1:0] wb_addr_o,
    output logic [dw-1:0]     wb_dat_o,
    output logic [dw/8-1:0]   wb_sel_o,
    output logic [2:0]        wb_cti_o,
    input  logic              wb_ack_i,
    input  logic [dw-1:0]     wb_dat_i,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [15:0]       err_count,
    output logic [APP_AW-1:0] first_err_addr
);

    localparam int unsigned SW = dw / 8;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [APP_AW-1:0] ADDR_STEP = APP_AW'(SW);
    localparam logic [APP_AW-1:0] BASE_MASK = ~APP_AW'(SW - 1);

`ifdef WB_TGEN_LFSR_EN
    localparam logic [31:0]   TAPS32 = (dw == 8)  ? 32'h0000_00B8 :
                                       (dw == 16) ? 32'h0000_B400 : 32'h8020_0003;
    localparam logic [dw-1:0] TAPS   = dw'(TAPS32);
    localparam logic [dw-1:0] SEED   = (dw'(PAT_SEED) == '0) ? dw'(1) : dw'(PAT_SEED);
`else
    localparam logic [dw-1:0] SEED   = dw'(PAT_SEED);
`endif

    typedef enum logic [2:0] {IDLE, WAIT_INIT, WR, WR_GAP, RD, RD_GAP, FIN} state_t;

    state_t            state_q, state_d;
    logic              cyc_q, cyc_d, we_q, we_d;
    logic [APP_AW-1:0] addr_q, addr_d, base_q, base_d, ferr_q, ferr_d;
    logic [dw-1:0]     dat_q, dat_d, pat_q, pat_d;
    logic [SW-1:0]     sel_q, sel_d, msel_q, msel_d;
    logic [2:0]        cti_q, cti_d;
    logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d, tmo_q, tmo_d;
    logic [15:0]       err_q, err_d, nb_q, nb_d, bcnt_q, bcnt_d;
    logic [4:0]        blen_q, blen_d, beat_q, beat_d;
    logic [TW-1:0]     to_q, to_d;
    logic [dw-1:0]     lane_mask;
    logic              ack, last_beat, mismatch;
    logic [4:0]        beat_nx;

    // Next pattern value after an acked beat.
    function automatic logic [dw-1:0] pat_next(input logic [dw-1:0] p);
`ifdef WB_TGEN_LFSR_EN
        return p[0] ? ((p >> 1) ^ TAPS) : (p >> 1);
`else
        return p + dw'(1);
`endif
    endfunction

    // Cycle type for beat index b of a burst of length len.
    function automatic logic [2:0] cti_for(input logic [4:0] b, input logic [4:0] len);
        if (len == 5'd1)         return 3'b000;
        if (b == len - 5'd1)     return 3'b111;
        return 3'b010;
    endfunction

    // Expand byte selects into a bit mask for the read compare.
    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < int'(SW); i++) lane_mask[8*i +: 8] = {8{msel_q[i]}};
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q; cyc_d = cyc_q; we_d = we_q; addr_d = addr_q; base_d = base_q;
        ferr_d = ferr_q; dat_d = dat_q; pat_d = pat_q; sel_d = sel_q; msel_d = msel_q;
        cti_d = cti_q; busy_d = busy_q; done_d = done_q; pass_d = pass_q; tmo_d = tmo_q;
        err_d = err_q; nb_d = nb_q; bcnt_d = bcnt_q; blen_d = blen_q; beat_d = beat_q;
        to_d = '0;
        ack       = wb_ack_i && cyc_q;
        last_beat = (beat_q == blen_q - 5'd1);
        beat_nx   = beat_q + 5'd1;
        mismatch  = |((wb_dat_i ^ pat_q) & lane_mask);

        case (state_q)
            IDLE: begin
                if (start) begin
                    done_d = 1'b0; pass_d = 1'b0; tmo_d = 1'b0; err_d = '0; ferr_d = '0;
                    busy_d = 1'b1;
                    base_d = cfg_base_addr & BASE_MASK;
                    addr_d = cfg_base_addr & BASE_MASK;
                    nb_d   = cfg_num_bursts;
                    msel_d = cfg_sel;
                    pat_d  = SEED;
                    bcnt_d = '0;
                    beat_d = '0;
                    if (cfg_burst_len == 5'd0)                blen_d = 5'd1;
                    else if (cfg_burst_len > 5'(BURST_MAX))   blen_d = 5'(BURST_MAX);
                    else                                      blen_d = cfg_burst_len;
                    state_d = (cfg_num_bursts == 16'd0) ? FIN : WAIT_INIT;
                end
            end
            WAIT_INIT: begin
                if (sdr_init_done) begin
                    state_d = WR; cyc_d = 1'b1; we_d = 1'b1; dat_d = pat_q;
                    sel_d = msel_q; cti_d = cti_for(5'd0, blen_q);
                end
            end
            WR, RD: begin
                if (ack) begin
                    addr_d = addr_q + ADDR_STEP;
                    pat_d  = pat_next(pat_q);
                    if (state_q == RD && mismatch) begin
                        if (err_q == 16'd0)      ferr_d = addr_q;
                        if (err_q != 16'hFFFF)   err_d  = err_q + 16'd1;
                    end
                    if (last_beat) begin
                        cyc_d   = 1'b0;
                        beat_d  = '0;
                        bcnt_d  = bcnt_q + 16'd1;
                        state_d = (state_q == WR) ? WR_GAP : RD_GAP;
                    end else begin
                        beat_d = beat_nx;
                        cti_d  = cti_for(beat_nx, blen_q);
                        if (state_q == WR) dat_d = pat_next(pat_q);
                    end
                end else if (to_q == TW'(TIMEOUT - 1)) begin
                    cyc_d = 1'b0; tmo_d = 1'b1; state_d = FIN;
                end else begin
                    to_d = to_q + TW'(1);
                end
            end
            WR_GAP: begin
                cyc_d = 1'b1;
                cti_d = cti_for(5'd0, blen_q);
                if (bcnt_q == nb_q) begin
                    // Write phase complete: replay address and pattern for the read-back.
                    state_d = RD; bcnt_d = '0; addr_d = base_q; pat_d = SEED;
                    we_d = 1'b0; dat_d = '0;
                end else begin
                    state_d = WR; dat_d = pat_q;
                end
            end
            RD_GAP: begin
                if (bcnt_q == nb_q) begin
                    state_d = FIN;
                end else begin
                    state_d = RD; cyc_d = 1'b1; cti_d = cti_for(5'd0, blen_q);
                end
            end
            FIN: begin
                busy_d = 1'b0; done_d = 1'b1;
                pass_d = (err_q == 16'd0) && !tmo_q;
                cyc_d = 1'b0; we_d = 1'b0; addr_d = '0; dat_d = '0; sel_d = '0; cti_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge sys_clk) begin
        if (!sys_resetn) begin
            state_q <= IDLE; cyc_q <= 1'b0; we_q <= 1'b0; addr_q <= '0; base_q <= '0;
            ferr_q <= '0; dat_q <= '0; pat_q <= '0; sel_q <= '0; msel_q <= '0; cti_q <= '0;
            busy_q <= 1'b0; done_q <= 1'b0; pass_q <= 1'b0; tmo_q <= 1'b0; err_q <= '0;
            nb_q <= '0; bcnt_q <= '0; blen_q <= '0; beat_q <= '0; to_q <= '0;
        end else begin
            state_q <= state_d; cyc_q <= cyc_d; we_q <= we_d; addr_q <= addr_d; base_q <= base_d;
            ferr_q <= ferr_d; dat_q <= dat_d; pat_q <= pat_d; sel_q <= sel_d; msel_q <= msel_d;
            cti_q <= cti_d; busy_q <= busy_d; done_q <= done_d; pass_q <= pass_d; tmo_q <= tmo_d;
            err_q <= err_d; nb_q <= nb_d; bcnt_q <= bcnt_d; blen_q <= blen_d; beat_q <= beat_d;
            to_q <= to_d;
        end
    end

    assign wb_cyc_o       = cyc_q;
    assign wb_stb_o       = cyc_q;
    assign wb_we_o        = we_q;
    assign wb_addr_o      = addr_q;
    assign wb_dat_o       = dat_q;
    assign wb_sel_o       = sel_q;
    assign wb_cti_o       = cti_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign timeout        = tmo_q;
    assign err_count      = err_q;
    assign first_err_addr = ferr_q;

endmodule

// File: tb/tb_wb_sdram_traffic_gen.sv
// Bench for wb_sdram_traffic_gen: memory-backed Wishbone slave, transaction-level
// expectation queue built from the pattern rules, and directed runs with literal results.
module tb_wb_sdram_traffic_gen;

    logic        clk, rstn, start, init_done;
    logic [25:0] cfg_base;
    logic [15:0] cfg_nb;
    logic [4:0]  cfg_len;
    logic [3:0]  cfg_sel;
    logic        cyc, stb, we, ack;
    logic [25:0] addr, ferr;
    logic [31:0] dat_o, dat_i;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic        busy, done, pass, tmo;
    logic [15:0] errc;

    wb_sdram_traffic_gen dut (
        .sys_clk(clk), .sys_resetn(rstn), .start(start),
        .cfg_base_addr(cfg_base), .cfg_num_bursts(cfg_nb), .cfg_burst_len(cfg_len),
        .cfg_sel(cfg_sel), .sdr_init_done(init_done),
        .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we), .wb_addr_o(addr), .wb_dat_o(dat_o),
        .wb_sel_o(sel), .wb_cti_o(cti), .wb_ack_i(ack), .wb_dat_i(dat_i),
        .busy(busy), .done(done), .pass(pass), .timeout(tmo),
        .err_count(errc), .first_err_addr(ferr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Slave: ideal (acks every stb cycle when enabled), 256-word memory, read corruption knobs.
    logic        ack_en;
    logic [31:0] mem [256];
    logic [25:0] corrupt_addr;
    logic [31:0] corrupt_all;
    assign ack = ack_en & cyc & stb;
    always_comb begin
        dat_i = mem[addr[9:2]] ^ corrupt_all;
        if (addr == corrupt_addr) dat_i = dat_i ^ 32'h1;
    end

    // Expected bus beats in order, derived from the pattern rules.
    typedef struct {
        logic [25:0] a;
        logic [31:0] d;
        logic [2:0]  c;
        logic        w;
        logic        last;
    } beat_t;
    beat_t       exp_q[$];
    logic [3:0]  exp_sel;
    logic [25:0] wl_addr[$];
    logic [31:0] wl_dat[$];
    logic [2:0]  wl_cti[$];
    int          cyc_cycles;
    int          gap_state;
    bit          chk_en;

    task automatic build(input logic [25:0] base, input int nb, input int len);
        int L;
        beat_t b;
        L = (len == 0) ? 1 : ((len > 8) ? 8 : len);
        exp_q.delete();
        for (int ph = 0; ph < 2; ph++)
            for (int k = 0; k < nb * L; k++) begin
                b.a    = (base & ~26'h3) + 26'(4 * k);
                b.d    = (ph == 0) ? 32'(1 + k) : 32'h0;
                b.w    = (ph == 0);
                b.last = ((k % L) == L - 1);
                b.c    = (L == 1) ? 3'b000 : (b.last ? 3'b111 : 3'b010);
                exp_q.push_back(b);
            end
    endtask

    // Per-cycle bus compare, gap checks, slave memory writes.
    initial begin
        beat_t h;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                if (gap_state == 1) begin
                    check("gap_low", 64'(cyc), 64'd0);
                    gap_state = 2;
                end else if (gap_state == 2) begin
                    if (exp_q.size() > 0 && ack_en) check("gap_resume", 64'(cyc), 64'd1);
                    gap_state = 0;
                end
                if (cyc) begin
                    cyc_cycles++;
                    check("beat_pending", 64'(exp_q.size() > 0), 64'd1);
                    if (exp_q.size() > 0) begin
                        h = exp_q[0];
                        check("beat_addr", 64'(addr), 64'(h.a));
                        check("beat_ctl", 64'({stb, we, dat_o, sel, cti}),
                              64'({1'b1, h.w, h.d, exp_sel, h.c}));
                        if (ack) begin
                            if (we) begin
                                for (int i = 0; i < 4; i++)
                                    if (sel[i]) mem[addr[9:2]][8*i +: 8] = dat_o[8*i +: 8];
                                wl_addr.push_back(addr);
                                wl_dat.push_back(dat_o);
                                wl_cti.push_back(cti);
                            end
                            void'(exp_q.pop_front());
                            if (h.last) gap_state = 1;
                        end
                    end
                end
            end
        end
    end

    task automatic wait_done(input string nm);
        for (int i = 0; i < 5000; i++) begin
            if (done) break;
            @(negedge clk);
        end
        check({nm, "_done"}, 64'(done), 64'd1);
    endtask

    task automatic pulse_start(input logic [25:0] base, input int nb, input int len,
                               input logic [3:0] s);
        build(base, nb, len);
        cyc_cycles = 0; gap_state = 0;
        wl_addr.delete(); wl_dat.delete(); wl_cti.delete();
        @(negedge clk);
        cfg_base = base; cfg_nb = 16'(nb); cfg_len = 5'(len); cfg_sel = s; exp_sel = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run(input string nm, input logic [25:0] base, input int nb, input int len,
                       input logic [3:0] s, input bit lat, input bit e_pass, input bit e_tmo,
                       input logic [15:0] e_err, input logic [25:0] e_ferr, input int e_cyc);
        pulse_start(base, nb, len, s);
        if (lat) begin
            check({nm, "_cyc_start_plus1"}, 64'(cyc), 64'd0);
            check({nm, "_busy"}, 64'(busy), 64'd1);
            @(negedge clk);
            check({nm, "_cyc_start_plus2"}, 64'(cyc), 64'd1);
        end
        wait_done(nm);
        check({nm, "_status"}, 64'({busy, pass, tmo}), 64'({1'b0, e_pass, e_tmo}));
        check({nm, "_err_count"}, 64'(errc), 64'(e_err));
        check({nm, "_first_err_addr"}, 64'(ferr), 64'(e_ferr));
        check({nm, "_cyc_cycles"}, 64'(cyc_cycles), 64'(e_cyc));
        if (!e_tmo) check({nm, "_beats_left"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        gap_state = 0;
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; init_done = 1'b1; ack_en = 1'b1;
        cfg_base = '0; cfg_nb = '0; cfg_len = '0; cfg_sel = '0; exp_sel = '0;
        corrupt_addr = 26'h3FF_FFFF; corrupt_all = '0;
        chk_en = 1'b0; cyc_cycles = 0; gap_state = 0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        check("reset_bus", 64'({cyc, stb, we, addr, dat_o}), 64'd0);
        check("reset_status", 64'({sel, cti, busy, done, pass, tmo, errc, ferr}), 64'd0);
        rstn = 1'b1;
        chk_en = 1'b1;

        // Basic run: writes 0x100..0x11C with 1..8, clean read-back.
        run("basic", 26'h100, 2, 4, 4'hF, 1, 1, 0, 16'd0, 26'h0, 16);
        check("wlog_n", 64'(wl_addr.size()), 64'd8);
        check("wlog0", 64'({wl_addr[0], wl_dat[0], wl_cti[0]}), 64'({26'h100, 32'd1, 3'b010}));
        check("wlog3_cti", 64'(wl_cti[3]), 64'd7);
        check("wlog4", 64'({wl_addr[4], wl_dat[4], wl_cti[4]}), 64'({26'h110, 32'd5, 3'b010}));
        check("wlog7", 64'({wl_addr[7], wl_dat[7], wl_cti[7]}), 64'({26'h11C, 32'd8, 3'b111}));

        // Single-bit read error at 0x108.
        corrupt_addr = 26'h108;
        run("bitflip", 26'h100, 2, 4, 4'hF, 0, 0, 0, 16'd1, 26'h108, 16);
        corrupt_addr = 26'h3FF_FFFF;

        // Upper lanes corrupted but masked off.
        corrupt_all = 32'hFFFF_0000;
        run("masked", 26'h100, 2, 4, 4'h3, 0, 1, 0, 16'd0, 26'h0, 16);
        corrupt_all = 32'hFFFF_FFFF;
        run("sel_zero", 26'h100, 1, 2, 4'h0, 0, 1, 0, 16'd0, 26'h0, 4);
        corrupt_all = '0;

        // Slave never acks.
        ack_en = 1'b0;
        run("timeout", 26'h100, 1, 4, 4'hF, 1, 0, 1, 16'd0, 26'h0, 1024);
        ack_en = 1'b1;

        // Empty run.
        run("zero_bursts", 26'h100, 0, 4, 4'hF, 0, 1, 0, 16'd0, 26'h0, 0);

        // Reset mid-burst, then a clean run.
        pulse_start(26'h100, 4, 8, 4'hF);
        for (int i = 0; i < 100; i++) begin
            if (cyc_cycles >= 5) break;
            @(negedge clk);
        end
        check("midburst_reached", 64'(cyc_cycles >= 5), 64'd1);
        chk_en = 1'b0;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        check("midreset_bus", 64'({cyc, stb, we, addr, dat_o}), 64'd0);
        check("midreset_status", 64'({sel, cti, busy, done, pass, tmo, errc, ferr}), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        exp_q.delete();
        gap_state = 0;
        chk_en = 1'b1;
        run("after_reset", 26'h100, 2, 4, 4'hF, 1, 1, 0, 16'd0, 26'h0, 16);

        // Single-beat bursts, misaligned base forced to word alignment.
        run("len1", 26'h142, 3, 1, 4'hF, 0, 1, 0, 16'd0, 26'h0, 6);
        check("len1_cti", 64'({wl_cti[0], wl_cti[2]}), 64'd0);
        check("len1_addr0", 64'(wl_addr[0]), 64'h140);

        // Oversized and zero burst lengths.
        run("len20", 26'h180, 1, 20, 4'hF, 0, 1, 0, 16'd0, 26'h0, 16);
        check("len20_beats", 64'(wl_addr.size()), 64'd8);
        run("len0", 26'h1C0, 2, 0, 4'hF, 0, 1, 0, 16'd0, 26'h0, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
